legv8_fetch_unit: RTL and testbench



---
 rtl/legv8_fetch_unit.sv | 133 +++++++++++++
 tb/tb_legv8_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/legv8_fetch_unit.sv
// LEGv8 instruction fetch stage: owns the PC, issues one-cycle-latency imem reads,
// and buffers returned words with their PC in a small prefetch FIFO for decode.
module legv8_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = 4,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic              halted
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    localparam logic [1:0] S_BOOT   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_issue_pc;
    logic              r_inflight;
    logic [31:0]       r_fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [1:0]        w_state_nxt;
    logic [OCC_W-1:0]  w_occ;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;

    // Occupancy after this edge if we do not issue: entries held, plus the word
    // arriving now, minus the one decode takes this cycle.
    assign w_occ   = {1'b0, r_count}
                   + {{CNT_W{1'b0}}, r_inflight}
                   - {{CNT_W{1'b0}}, w_pop};
    assign w_pop   = out_valid & out_ready;
    assign w_push  = r_inflight & ~redirect;
    assign w_issue = (r_state == S_RUN) & ~redirect & ~halt
                   & (w_occ < OCC_W'(FIFO_DEPTH));

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign out_valid = (r_count != '0) & ~redirect;
    assign out_instr = r_fifo_instr[r_rd_ptr];
    assign out_pc    = r_fifo_pc[r_rd_ptr];
    assign halted    = (r_state == S_HALTED);

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = halt ? S_DRAIN : S_RUN;
        end else begin
            case (r_state)
                S_BOOT:   w_state_nxt = S_RUN;
                S_RUN:    if (halt) w_state_nxt = S_DRAIN;
                S_DRAIN: begin
                    if (!halt)
                        w_state_nxt = S_RUN;
                    else if ((r_count == '0) && !r_inflight)
                        w_state_nxt = S_HALTED;
                end
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_issue_pc <= '0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            // NOTE: the storage is reset too because the head entry drives
            // out_instr/out_pc, which must read zero straight out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (redirect) begin
                // Flush; clearing inflight squashes the response on imem_data now.
                r_pc       <= redirect_target;
                r_inflight <= 1'b0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc       <= r_pc + ADDR_W'(PC_STEP);
                    r_issue_pc <= r_pc;
                end
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= imem_data;
                    r_fifo_pc[r_wr_ptr]    <= r_issue_pc;
                    r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_push && !w_pop)
                    r_count <= r_count + CNT_W'(1);
                else if (!w_push && w_pop)
                    r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Bench for legv8_fetch_unit: directed cycle checks plus an in-order PC/instruction
// scoreboard; a second instance with RESET_PC near the top of memory covers PC wrap.
module tb_legv8_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        imem_req, out_valid, out_ready, redirect, halt, halted;
    logic [31:0] imem_addr, imem_data, out_instr, out_pc, redirect_target;

    logic        wr_imem_req, wr_out_valid, wr_halted;
    logic [31:0] wr_imem_addr, wr_imem_data, wr_out_instr, wr_out_pc;

    legv8_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect(redirect), .redirect_target(redirect_target),
        .halt(halt), .halted(halted)
    );

    legv8_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(wr_imem_req), .imem_addr(wr_imem_addr), .imem_data(wr_imem_data),
        .out_valid(wr_out_valid), .out_ready(1'b1),
        .out_instr(wr_out_instr), .out_pc(wr_out_pc),
        .redirect(1'b0), .redirect_target(32'h0),
        .halt(1'b0), .halted(wr_halted)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Instruction memory: word at addr is addr+0x100, returned one cycle after the request.
    logic        req_s = 1'b0, wr_req_s = 1'b0;
    logic [31:0] addr_s = '0, wr_addr_s = '0;
    initial begin
        imem_data    = '0;
        wr_imem_data = '0;
    end
    always @(negedge clk) begin
        req_s     = imem_req;
        addr_s    = imem_addr;
        wr_req_s  = wr_imem_req;
        wr_addr_s = wr_imem_addr;
    end
    always @(posedge clk) begin
        #1;
        imem_data    = req_s    ? addr_s    + 32'h100 : 32'hDEAD_BEEF;
        wr_imem_data = wr_req_s ? wr_addr_s + 32'h100 : 32'hDEAD_BEEF;
    end

    // Scoreboard: expected delivery PCs in order; instruction is PC+0x100.
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_extra: got pc 0x%08h, expected no delivery", out_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                check("sb_pc", out_pc, exp_pc);
                check("sb_instr", out_instr, exp_pc + 32'h100);
            end
        end
    end

    // Wrap instance: record its first two requests and first two deliveries.
    logic [31:0] wr_req_q[$], wr_pc_q[$], wr_instr_q[$];
    always @(negedge clk) begin
        if (reset) begin
            if (wr_imem_req && wr_req_q.size() < 2) wr_req_q.push_back(wr_imem_addr);
            if (wr_out_valid && wr_pc_q.size() < 2) begin
                wr_pc_q.push_back(wr_out_pc);
                wr_instr_q.push_back(wr_out_instr);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] tgt, input logic hlt);
        @(posedge clk);
        #1;
        out_ready       = rdy;
        redirect        = redir;
        redirect_target = tgt;
        halt            = hlt;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"},  imem_req,  0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_instr"}, out_instr, 0);
        check({tag, "_out_pc"},    out_pc,    0);
        check({tag, "_halted"},    halted,    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_target = '0; halt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");

        // Boot with decode always ready, then backpressure.
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        @(posedge clk); #1; reset = 1'b1; out_ready = 1'b1;
        @(negedge clk);                                           // BOOT
        check("boot_req", imem_req, 0);
        cyc(1, 0, 0, 0);
        check("k1_req", imem_req, 1);  check("k1_addr", imem_addr, 32'h0);
        check("k1_valid", out_valid, 0);
        cyc(1, 0, 0, 0);
        check("k2_req", imem_req, 1);  check("k2_addr", imem_addr, 32'h4);
        check("k2_valid", out_valid, 0);
        cyc(1, 0, 0, 0);
        check("k3_valid", out_valid, 1); check("k3_addr", imem_addr, 32'h8);
        cyc(1, 0, 0, 0);
        check("k4_addr", imem_addr, 32'hC);
        cyc(0, 0, 0, 0);
        check("bp_k5_req", imem_req, 0);
        cyc(0, 0, 0, 0);
        check("bp_k6_req", imem_req, 0); check("bp_k6_valid", out_valid, 1);
        check("bp_k6_pc", out_pc, 32'h8); check("bp_k6_instr", out_instr, 32'h108);
        cyc(0, 0, 0, 0);
        check("bp_k7_req", imem_req, 0); check("bp_k7_pc", out_pc, 32'h8);
        cyc(1, 0, 0, 0);
        check("k8_req", imem_req, 1);  check("k8_addr", imem_addr, 32'h10);

        // Redirect while PC 12 is buffered and PC 16 is returning.
        cyc(1, 1, 32'h40, 0);
        check("redir_valid", out_valid, 0); check("redir_req", imem_req, 0);
        exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
        exp_q.push_back(32'h4C); exp_q.push_back(32'h50);
        cyc(1, 0, 0, 0);
        check("redir_addr", imem_addr, 32'h40); check("redir_req1", imem_req, 1);
        repeat (4) cyc(1, 0, 0, 0);
        check("pre_halt_addr", imem_addr, 32'h50);

        // Halt and drain.
        cyc(1, 0, 0, 1);
        check("halt_req_a", imem_req, 0);
        cyc(1, 0, 0, 1);
        check("halt_req_b", imem_req, 0); check("drain_halted", halted, 0);
        cyc(1, 0, 0, 1);
        check("drain_valid", out_valid, 0); check("drain_halted2", halted, 0);
        cyc(1, 0, 0, 1);
        check("halted_set", halted, 1); check("halted_req", imem_req, 0);
        cyc(1, 0, 0, 0);
        check("halted_hold", halted, 1); check("halted_req2", imem_req, 0);
        exp_q.push_back(32'h80); exp_q.push_back(32'h84);
        cyc(1, 1, 32'h80, 0);
        check("resume_redir_req", imem_req, 0);
        cyc(1, 0, 0, 0);
        check("resume_halted", halted, 0);
        check("resume_req", imem_req, 1); check("resume_addr", imem_addr, 32'h80);
        cyc(1, 0, 0, 0);
        check("resume_addr2", imem_addr, 32'h84);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("full_valid", out_valid, 1); check("full_pc", out_pc, 32'h88);
        check("full_req", imem_req, 0);
        check("sb_drained", exp_q.size(), 0);

        // PC wrap on the second instance.
        check("wrap_nreq", wr_req_q.size(), 2);
        check("wrap_nout", wr_pc_q.size(), 2);
        if (wr_req_q.size() == 2) begin
            check("wrap_req0", wr_req_q[0], 32'hFFFF_FFFC);
            check("wrap_req1", wr_req_q[1], 32'h0000_0000);
        end
        if (wr_pc_q.size() == 2) begin
            check("wrap_pc0", wr_pc_q[0], 32'hFFFF_FFFC);
            check("wrap_instr0", wr_instr_q[0], 32'h0000_00FC);
            check("wrap_pc1", wr_pc_q[1], 32'h0000_0000);
            check("wrap_instr1", wr_instr_q[1], 32'h0000_0100);
        end

        // Asynchronous reset between edges with the FIFO full.
        #2; reset = 1'b0;
        #1; check_reset_outputs("async");
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        repeat (2) @(posedge clk);
        #1; reset = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("reboot_req", imem_req, 0); check("reboot_valid", out_valid, 0);
        cyc(1, 0, 0, 0);
        check("reboot_addr", imem_addr, 32'h0); check("reboot_req1", imem_req, 1);
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("sb_final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
